// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the icache/dcache memory arbiter.
// Holds FSM states, client IDs and the memory-tag split helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WDATA
    } arb_state_t;

    localparam logic CLIENT_ICACHE = 1'b0;
    localparam logic CLIENT_DCACHE = 1'b1;

    // Memory tag = {client id, client tag}; the id sits in the MSB.
    function automatic int cid_bit(input int tag_bits);
        return tag_bits - 1;
    endfunction

    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a priority pointer.
// The pointer moves past the served client on each advance strobe.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       adv_id,
    output logic       win,
    output logic       prio
);

    logic prio_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q <= CLIENT_ICACHE;
        end else if (advance) begin
            prio_q <= ~adv_id;
        end
    end

    assign prio = prio_q;
    assign win  = (req[0] && req[1]) ? prio_q : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares the external memory port between icache (0) and dcache (1).
// Round-robin request grant, line-locked write data, tag-steered responses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS  = 28,
    parameter int DATA_BITS  = 128,
    parameter int TAG_BITS   = 5,
    parameter int DATA_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   c0_req_valid,
    output logic                   c0_req_ready,
    input  logic                   c0_req_rw,
    input  logic [ADDR_BITS-1:0]   c0_req_addr,
    input  logic [TAG_BITS-2:0]    c0_req_tag,
    input  logic                   c0_req_data_valid,
    output logic                   c0_req_data_ready,
    input  logic [DATA_BITS-1:0]   c0_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
    output logic                   c0_resp_valid,
    output logic [TAG_BITS-2:0]    c0_resp_tag,
    output logic [DATA_BITS-1:0]   c0_resp_data,

    input  logic                   c1_req_valid,
    output logic                   c1_req_ready,
    input  logic                   c1_req_rw,
    input  logic [ADDR_BITS-1:0]   c1_req_addr,
    input  logic [TAG_BITS-2:0]    c1_req_tag,
    input  logic                   c1_req_data_valid,
    output logic                   c1_req_data_ready,
    input  logic [DATA_BITS-1:0]   c1_req_data_bits,
    input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
    output logic                   c1_resp_valid,
    output logic [TAG_BITS-2:0]    c1_resp_tag,
    output logic [DATA_BITS-1:0]   c1_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,

    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int CID    = cid_bit(TAG_BITS);
    localparam int BEAT_W = beat_width(DATA_BEATS);
    localparam logic [BEAT_W-1:0] LAST =
        BEAT_W'(DATA_BEATS - 1);

    arb_state_t        state, state_n;
    logic              grant, grant_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic              win, prio, advance;

    logic                   sel_rw;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic [TAG_BITS-2:0]    sel_tag;
    logic                   sel_dvalid;
    logic [DATA_BITS-1:0]   sel_dbits;
    logic [DATA_BITS/8-1:0] sel_dmask;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({c1_req_valid, c0_req_valid}),
        .advance (advance),
        .adv_id  (grant),
        .win     (win),
        .prio    (prio)
    );

    // Grant resets to the icache, so idle outputs follow client 0.
    always_comb begin
        sel_rw     = c0_req_rw;
        sel_addr   = c0_req_addr;
        sel_tag    = c0_req_tag;
        sel_dvalid = c0_req_data_valid;
        sel_dbits  = c0_req_data_bits;
        sel_dmask  = c0_req_data_mask;
        if (grant == CLIENT_DCACHE) begin
            sel_rw     = c1_req_rw;
            sel_addr   = c1_req_addr;
            sel_tag    = c1_req_tag;
            sel_dvalid = c1_req_data_valid;
            sel_dbits  = c1_req_data_bits;
            sel_dmask  = c1_req_data_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            grant <= CLIENT_ICACHE;
            beat  <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            beat  <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        beat_n  = beat;
        advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (c0_req_valid || c1_req_valid) begin
                    grant_n = win;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    advance = 1'b1;
                    beat_n  = '0;
                    state_n = sel_rw ? WDATA : IDLE;
                end
            end
            WDATA: begin
                if (sel_dvalid && mem_req_data_ready) begin
                    if (beat == LAST) begin
                        beat_n  = '0;
                        state_n = IDLE;
                    end else begin
                        beat_n = beat + BEAT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic in_req, in_wd;
    assign in_req = (state == REQ);
    assign in_wd  = (state == WDATA);

    assign mem_req_valid = in_req;
    assign mem_req_rw    = sel_rw;
    assign mem_req_addr  = sel_addr;
    assign mem_req_tag   = {grant, sel_tag};

    assign c0_req_ready = in_req && (grant == CLIENT_ICACHE)
                          && mem_req_ready;
    assign c1_req_ready = in_req && (grant == CLIENT_DCACHE)
                          && mem_req_ready;

    assign mem_req_data_valid = in_wd && sel_dvalid;
    assign mem_req_data_bits  = sel_dbits;
    assign mem_req_data_mask  = sel_dmask;

    assign c0_req_data_ready = in_wd && (grant == CLIENT_ICACHE)
                               && mem_req_data_ready;
    assign c1_req_data_ready = in_wd && (grant == CLIENT_DCACHE)
                               && mem_req_data_ready;

    assign c0_resp_valid = mem_resp_valid
                           && (mem_resp_tag[CID] == CLIENT_ICACHE);
    assign c1_resp_valid = mem_resp_valid
                           && (mem_resp_tag[CID] == CLIENT_DCACHE);
    assign c0_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign c1_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign c0_resp_data  = mem_resp_data;
    assign c1_resp_data  = mem_resp_data;

endmodule
